div_reconstruct_mul: RTL and testbench

//  Sequential shift-add multiply-accumulate that inverts the unsigned divider:

---
 rtl/div_reconstruct_mul.sv | 107 ++++++++++
 tb/tb_div_reconstruct_mul.sv | 167 ++++++++++++++++
 2 files changed

// File: rtl/div_reconstruct_mul.sv
// Rebuilds a dividend a = q*b + r by shift-add multiply then a final add; usable as a plain multiplier with r = 0.
// Result valid WIDTH+1 edges after acceptance; one operation in flight, result held until out_ready.
module div_reconstruct_mul #(
  parameter int WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [WIDTH-1:0]     q,
  input  logic [WIDTH-1:0]     b,
  input  logic [WIDTH-1:0]     r,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [2*WIDTH-1:0]   a,
  output logic                 overflow,
  output logic                 rem_err
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

  typedef enum logic [1:0] {S_IDLE, S_MUL, S_ADD, S_DONE} state_t;

  state_t               r_state;
  state_t               w_nxt_state;
  logic [WIDTH-1:0]     r_q_sh;
  logic [WIDTH-1:0]     r_b;
  logic [WIDTH-1:0]     r_r;
  logic [2*WIDTH-1:0]   r_acc;
  logic [CW-1:0]        r_cnt;
  logic                 r_rem_err_pend;
  logic [2*WIDTH-1:0]   r_a;
  logic                 r_overflow;
  logic                 r_rem_err;
  logic [2*WIDTH-1:0]   w_addend;
  logic [2*WIDTH-1:0]   w_sum;

  assign w_addend = {{WIDTH{1'b0}}, r_b} << r_cnt;
  assign w_sum    = r_acc + {{WIDTH{1'b0}}, r_r};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_nxt_state;
  end

  always_comb begin
    w_nxt_state = r_state;
    case (r_state)
      S_IDLE: if (in_valid)          w_nxt_state = S_MUL;
      S_MUL:  if (r_cnt == LAST_BIT) w_nxt_state = S_ADD;
      S_ADD:                         w_nxt_state = S_DONE;
      S_DONE: if (out_ready)         w_nxt_state = S_IDLE;
      default:                       w_nxt_state = S_IDLE;
    endcase
  end

  always_comb begin
    in_ready  = (r_state == S_IDLE);
    out_valid = (r_state == S_DONE);
  end

  // Datapath: operands latched only on acceptance; outputs change only on the ADD edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_q_sh         <= '0;
      r_b            <= '0;
      r_r            <= '0;
      r_acc          <= '0;
      r_cnt          <= '0;
      r_rem_err_pend <= 1'b0;
      r_a            <= '0;
      r_overflow     <= 1'b0;
      r_rem_err      <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (in_valid) begin
            r_q_sh         <= q;
            r_b            <= b;
            r_r            <= r;
            r_acc          <= '0;
            r_cnt          <= '0;
            r_rem_err_pend <= (r >= b);
          end
        end
        S_MUL: begin
          if (r_q_sh[0]) r_acc <= r_acc + w_addend;
          r_q_sh <= r_q_sh >> 1;
          r_cnt  <= r_cnt + 1'b1;
        end
        S_ADD: begin
          r_acc      <= w_sum;
          r_a        <= w_sum;
          r_overflow <= |w_sum[2*WIDTH-1:WIDTH];
          r_rem_err  <= r_rem_err_pend;
        end
        default: ;
      endcase
    end
  end

  assign a        = r_a;
  assign overflow = r_overflow;
  assign rem_err  = r_rem_err;

endmodule

// File: tb/tb_div_reconstruct_mul.sv
// Directed and round-trip checks of div_reconstruct_mul (WIDTH=8) against hand-computed values.
module tb_div_reconstruct_mul;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [7:0]  q;
  logic [7:0]  b;
  logic [7:0]  r;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] a;
  logic        overflow;
  logic        rem_err;

  int n_chk;
  int n_err;

  div_reconstruct_mul #(.WIDTH(8)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .q         (q),
    .b         (b),
    .r         (r),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .a         (a),
    .overflow  (overflow),
    .rem_err   (rem_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", tag, got, got, exp, exp);
    end
  endtask

  // Waits for in_ready, presents operands for one edge, then scrambles them and counts edges to out_valid.
  task automatic run_op(input logic [7:0] qq, input logic [7:0] bb, input logic [7:0] rr, output int lat);
    int w;
    w = 0;
    while (!in_ready && w < 50) begin
      @(posedge clk); #1;
      w++;
    end
    chk("in_ready_before_op", in_ready, 1);
    q = qq; b = bb; r = rr; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    q = 8'($urandom); b = 8'($urandom); r = 8'($urandom);
    lat = 0;
    while (!out_valid && lat < 50) begin
      @(posedge clk); #1;
      lat++;
    end
  endtask

  task automatic handshake(input int stall);
    repeat (stall) begin
      @(posedge clk); #1;
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    chk("out_valid_after_hs", out_valid, 0);
    chk("in_ready_after_hs", in_ready, 1);
  endtask

  initial begin
    int lat;
    logic [7:0] dvd;
    logic [7:0] dvs;
    n_chk = 0; n_err = 0;
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    q = '0; b = '0; r = '0;
    #2;
    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_a", a, 0);
    chk("rst_overflow", overflow, 0);
    chk("rst_rem_err", rem_err, 0);
    @(negedge clk);
    rst_n = 1'b1;

    run_op(8'd13, 8'd11, 8'd7, lat);
    chk("lat_13x11", lat, 9);
    chk("a_13x11+7", a, 150);
    chk("ovf_13x11", overflow, 0);
    chk("rem_13x11", rem_err, 0);
    handshake(0);
    chk("a_hold_after_hs", a, 150);

    run_op(8'd255, 8'd255, 8'd254, lat);
    chk("lat_max", lat, 9);
    chk("a_max", a, 16'hFEFF);
    chk("ovf_max", overflow, 1);
    chk("rem_max", rem_err, 0);
    handshake(1);

    run_op(8'd5, 8'd0, 8'd3, lat);
    chk("a_b0", a, 3);
    chk("ovf_b0", overflow, 0);
    chk("rem_b0", rem_err, 1);
    handshake(0);

    run_op(8'd0, 8'd9, 8'd9, lat);
    chk("lat_q0", lat, 9);
    chk("a_q0", a, 9);
    chk("rem_q0", rem_err, 1);
    // Hold off the consumer while hammering the input side with new operands.
    for (int i = 0; i < 5; i++) begin
      in_valid = i[0] ? 1'b0 : 1'b1;
      q = 8'(i + 40); b = 8'(i + 3); r = 8'(i);
      @(posedge clk); #1;
      chk("bp_out_valid", out_valid, 1);
      chk("bp_in_ready", in_ready, 0);
      chk("bp_a", a, 9);
      chk("bp_rem", rem_err, 1);
      chk("bp_ovf", overflow, 0);
    end
    in_valid = 1'b0;
    handshake(0);

    // Reset in the middle of the multiply phase.
    q = 8'd200; b = 8'd200; r = 8'd0; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    chk("midrst_out_valid", out_valid, 0);
    chk("midrst_in_ready", in_ready, 1);
    chk("midrst_a", a, 0);
    chk("midrst_rem", rem_err, 0);
    @(negedge clk);
    rst_n = 1'b1;
    run_op(8'd2, 8'd3, 8'd1, lat);
    chk("lat_after_rst", lat, 9);
    chk("a_after_rst", a, 7);
    chk("ovf_after_rst", overflow, 0);
    handshake(2);

    // Round trip through an ideal divider with random consumer stalls.
    for (int i = 0; i < 1000; i++) begin
      dvd = 8'($urandom_range(0, 255));
      dvs = 8'($urandom_range(1, 255));
      run_op(dvd / dvs, dvs, dvd % dvs, lat);
      chk("rt_a", a, {24'd0, dvd});
      chk("rt_ovf", overflow, 0);
      chk("rt_rem", rem_err, 0);
      handshake($urandom_range(0, 3));
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
